// File: rtl/decode_buffer_ctrl.sv
// decode_buffer_ctrl
//   Instruction buffer and dispatch scheduler between fetch and stage_decode.
//   Fetch bundles (up to N lanes, each qualified by .valid) are compacted and
//   pushed into a DEPTH-entry circular queue. Each cycle the oldest entries are
//   presented to the decoder, as many as the backend reports it can accept.
//   A squash flushes the queue and drops the incoming bundle.
//
// Ports
//   clock          : single clock, state updates on posedge
//   reset          : asynchronous, active-low
//   if_id_packet   : fetch bundle, N lanes of IF_ID_PACKET
//   dispatch_avail : instructions the backend accepts this cycle (>N treated as N)
//   squash         : mispredict flush, highest priority
//   if_stall       : fetch must hold its bundle (not enqueued this cycle)
//   id_packet      : bundle to stage_decode, lanes 0..k-1 valid, the rest zero
//   count          : current occupancy
//
// Build option
//   DECODE_BYPASS_EN : when defined and the queue is empty, the incoming
//                      compacted lanes drive id_packet in the same cycle and
//                      only the leftover lanes are enqueued.
//   N (macro)        : default superscalar width, 2 if not defined elsewhere.

`ifndef N
`define N 2
`endif

package decode_buffer_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] PC;
        logic [31:0] inst;
    } IF_ID_PACKET;
endpackage

module decode_buffer_ctrl
    import decode_buffer_pkg::*;
#(
    parameter int N     = `N,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  IF_ID_PACKET [N-1:0]    if_id_packet,
    input  logic [$clog2(N+1)-1:0] dispatch_avail,
    input  logic                   squash,
    output logic                   if_stall,
    output IF_ID_PACKET [N-1:0]    id_packet,
    output logic [CNT_W-1:0]       count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    IF_ID_PACKET          mem [DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;

    IF_ID_PACKET [N-1:0]  comp;     // valid lanes packed toward lane 0
    IF_ID_PACKET [N-1:0]  enq_pkt;  // lanes actually written to the queue
    int unsigned          e;        // number of valid incoming lanes
    int unsigned          avail;    // dispatch_avail clamped to N
    int unsigned          k;        // entries dequeued this cycle
    int unsigned          skip;     // incoming lanes consumed by bypass
    int unsigned          n_enq;    // entries written this cycle
    logic [PTR_W-1:0]     rd_idx;

    // Stall uses registered occupancy only; same-cycle dequeues are not credited.
    assign if_stall = (32'(DEPTH) - 32'(count)) < 32'(N);

    always_comb begin
        comp      = '0;
        enq_pkt   = '0;
        id_packet = '0;
        e         = 0;
        k         = 0;
        skip      = 0;
        n_enq     = 0;
        rd_idx    = '0;

        // Compaction: lane i lands at position = number of valid lanes below it.
        for (int unsigned i = 0; i < N; i++) begin
            if (if_id_packet[i].valid) begin
                for (int unsigned j = 0; j < N; j++) begin
                    if (j == e) comp[j] = if_id_packet[i];
                end
                e = e + 1;
            end
        end

        avail = (32'(dispatch_avail) > 32'(N)) ? 32'(N) : 32'(dispatch_avail);

        if (!squash) begin
            if (count != '0) begin
                k = (32'(count) < avail) ? 32'(count) : avail;
                for (int unsigned i = 0; i < N; i++) begin
                    if (i < k) begin
                        rd_idx             = head + PTR_W'(i);
                        id_packet[i]       = mem[rd_idx];
                        id_packet[i].valid = 1'b1;
                    end
                end
            end
`ifdef DECODE_BYPASS_EN
            else if (!if_stall) begin
                skip = (e < avail) ? e : avail;
                for (int unsigned i = 0; i < N; i++) begin
                    if (i < skip) id_packet[i] = comp[i];
                end
            end
`endif
        end

`ifdef DECODE_BYPASS_EN
        // Shift out the lanes already handed to the decoder by the bypass.
        for (int unsigned s = 0; s < N; s++) begin
            for (int unsigned i = s; i < N; i++) begin
                if (s == skip) enq_pkt[i - s] = comp[i];
            end
        end
`else
        enq_pkt = comp;
`endif

        if (!if_stall && !squash) n_enq = e - skip;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (squash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(k);
            tail  <= tail + PTR_W'(n_enq);
            count <= count + CNT_W'(n_enq) - CNT_W'(k);
        end
    end

    // Storage needs no reset; liveness is tracked by head/count.
    always_ff @(posedge clock) begin
        for (int unsigned j = 0; j < N; j++) begin
            if (j < n_enq) mem[tail + PTR_W'(j)] <= enq_pkt[j];
        end
    end

endmodule

// File: tb/tb_decode_buffer_ctrl.sv
// Testbench for decode_buffer_ctrl (N=2, DEPTH=8). Directed scenarios followed
// by randomized traffic, all checked against a queue-based reference model.

`ifndef N
`define N 2
`endif

module tb_decode_buffer_ctrl;
    import decode_buffer_pkg::*;

    localparam int NL    = 2;
    localparam int DEPTH = 8;

    typedef IF_ID_PACKET [NL-1:0] bundle_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    bundle_t     if_id_packet = '0;
    bundle_t     id_packet;
    logic [1:0]  dispatch_avail = '0;
    logic        squash = 1'b0;
    logic        if_stall;
    logic [3:0]  count;

    decode_buffer_ctrl #(.N(NL), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .if_id_packet   (if_id_packet),
        .dispatch_avail (dispatch_avail),
        .squash         (squash),
        .if_stall       (if_stall),
        .id_packet      (id_packet),
        .count          (count)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int errors  = 0;

    // Reference model: a plain FIFO of instructions.
    IF_ID_PACKET q[$];
    IF_ID_PACKET inc[$];
    bundle_t     exp_id;
    logic        exp_stall;
    int          m_k;
    int          m_byp;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bundle_t mk(input logic v0, input logic [31:0] pc0,
                                   input logic v1, input logic [31:0] pc1);
        bundle_t b;
        b[0].valid = v0;
        b[0].PC    = pc0;
        b[0].inst  = $urandom();
        b[1].valid = v1;
        b[1].PC    = pc1;
        b[1].inst  = $urandom();
        return b;
    endfunction

    function automatic void model_eval();
        int av;
        av = (dispatch_avail > 2'd2) ? 2 : int'(dispatch_avail);
        exp_stall = (DEPTH - q.size()) < NL;
        exp_id    = '0;
        m_k       = 0;
        m_byp     = 0;
        inc.delete();
        for (int i = 0; i < NL; i++)
            if (if_id_packet[i].valid) inc.push_back(if_id_packet[i]);
        if (!squash) begin
            if (q.size() > 0) begin
                m_k = (q.size() < av) ? q.size() : av;
                for (int i = 0; i < m_k; i++) begin
                    exp_id[i]       = q[i];
                    exp_id[i].valid = 1'b1;
                end
            end
`ifdef DECODE_BYPASS_EN
            else if (!exp_stall) begin
                m_byp = (inc.size() < av) ? inc.size() : av;
                for (int i = 0; i < m_byp; i++) exp_id[i] = inc[i];
            end
`endif
        end
    endfunction

    function automatic void model_commit();
        if (squash) begin
            q.delete();
        end else begin
            repeat (m_k) void'(q.pop_front());
            if (!exp_stall)
                for (int i = m_byp; i < inc.size(); i++) q.push_back(inc[i]);
        end
    endfunction

    // Apply inputs just after an edge, then compare at the falling edge.
    task automatic drive(input bundle_t b, input logic [1:0] av, input logic sq);
        if_id_packet   = b;
        dispatch_avail = av;
        squash         = sq;
        @(negedge clock);
        model_eval();
        chk("count",     256'(count),     256'(q.size()));
        chk("if_stall",  256'(if_stall),  256'(exp_stall));
        chk("id_packet", 256'(id_packet), 256'(exp_id));
    endtask

    task automatic tick();
        model_commit();
        @(posedge clock);
        #1;
    endtask

    bundle_t idle;
    bundle_t rb;

    initial begin
        idle = '0;

        // Reset state
        #12;
        chk("rst_count",  256'(count),     256'(0));
        chk("rst_stall",  256'(if_stall),  256'(0));
        chk("rst_id",     256'(id_packet), 256'(0));
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Fill until stall with no dispatch
        for (int i = 0; i < 4; i++) begin
            drive(mk(1'b1, 32'h1000 + 32'(8 * i), 1'b1, 32'h1004 + 32'(8 * i)), 2'd0, 1'b0);
            tick();
        end
        drive(idle, 2'd0, 1'b0);
        chk("fill_count", 256'(count),    256'(8));
        chk("fill_stall", 256'(if_stall), 256'(1));
        tick();
        drive(mk(1'b1, 32'h2000, 1'b1, 32'h2004), 2'd0, 1'b0);
        tick();
        drive(idle, 2'd0, 1'b0);
        chk("fill_no_enq", 256'(count), 256'(8));
        tick();
        drive(idle, 2'd0, 1'b1);
        tick();

        // Partial dispatch from count=3
        drive(mk(1'b1, 32'h100, 1'b1, 32'h104), 2'd0, 1'b0);
        tick();
        drive(mk(1'b1, 32'h108, 1'b0, 32'hdead), 2'd0, 1'b0);
        tick();
        drive(idle, 2'd1, 1'b0);
        chk("part_count",    256'(count),            256'(3));
        chk("part_lane0_pc", 256'(id_packet[0].PC),    256'(32'h100));
        chk("part_lane0_v",  256'(id_packet[0].valid), 256'(1));
        chk("part_lane1",    256'(id_packet[1]),       256'(0));
        tick();
        drive(idle, 2'd1, 1'b0);
        chk("part_count2",   256'(count),            256'(2));
        chk("part_next_pc",  256'(id_packet[0].PC),  256'(32'h104));
        tick();

        // Squash with count=4 and a valid incoming bundle
        drive(mk(1'b1, 32'h10c, 1'b1, 32'h110), 2'd0, 1'b0);
        tick();
        drive(mk(1'b1, 32'h114, 1'b0, 32'h0), 2'd0, 1'b0);
        tick();
        drive(mk(1'b1, 32'h500, 1'b1, 32'h504), 2'd2, 1'b1);
        chk("sq_pre_count", 256'(count),     256'(4));
        chk("sq_id_zero",   256'(id_packet), 256'(0));
        tick();
        drive(idle, 2'd0, 1'b0);
        chk("sq_count", 256'(count), 256'(0));
        tick();

        // Compaction and wrap: bring head=tail=7, then straddle 7->0
        for (int i = 0; i < 3; i++) begin
            drive(mk(1'b1, 32'h600 + 32'(8 * i), 1'b1, 32'h604 + 32'(8 * i)), 2'd0, 1'b0);
            tick();
        end
        drive(mk(1'b1, 32'h618, 1'b0, 32'h0), 2'd0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(idle, 2'd2, 1'b0);
            tick();
        end
        drive(idle, 2'd1, 1'b0);
        tick();
        drive(mk(1'b0, 32'hbad0, 1'b1, 32'h40), 2'd0, 1'b0);
        tick();
        drive(mk(1'b1, 32'h44, 1'b1, 32'h48), 2'd0, 1'b0);
        chk("wrap_count1", 256'(count), 256'(1));
        tick();
        drive(idle, 2'd2, 1'b0);
        chk("wrap_count3", 256'(count),           256'(3));
        chk("wrap_pc0",    256'(id_packet[0].PC), 256'(32'h40));
        chk("wrap_pc1",    256'(id_packet[1].PC), 256'(32'h44));
        tick();
        drive(idle, 2'd2, 1'b0);
        chk("wrap_pc2",    256'(id_packet[0].PC), 256'(32'h48));
        chk("wrap_lane1",  256'(id_packet[1]),    256'(0));
        tick();

        // Bypass scenario on an empty queue
        drive(mk(1'b1, 32'h80, 1'b1, 32'h84), 2'd1, 1'b0);
`ifdef DECODE_BYPASS_EN
        chk("byp_pc0",   256'(id_packet[0].PC),    256'(32'h80));
        chk("byp_v0",    256'(id_packet[0].valid), 256'(1));
`else
        chk("byp_off_id", 256'(id_packet), 256'(0));
`endif
        tick();
        drive(idle, 2'd1, 1'b0);
`ifdef DECODE_BYPASS_EN
        chk("byp_count", 256'(count),           256'(1));
        chk("byp_head",  256'(id_packet[0].PC), 256'(32'h84));
`else
        chk("byp_off_count", 256'(count),           256'(2));
        chk("byp_off_head",  256'(id_packet[0].PC), 256'(32'h80));
`endif
        tick();
        drive(idle, 2'd0, 1'b1);
        tick();

        // Asynchronous reset mid-run with count=5
        drive(mk(1'b1, 32'h200, 1'b1, 32'h204), 2'd0, 1'b0);
        tick();
        drive(mk(1'b1, 32'h208, 1'b1, 32'h20c), 2'd0, 1'b0);
        tick();
        drive(mk(1'b0, 32'h0, 1'b1, 32'h210), 2'd0, 1'b0);
        tick();
        drive(idle, 2'd2, 1'b0);
        chk("pre_rst_count", 256'(count), 256'(5));
        #2 reset = 1'b0;
        #1;
        chk("arst_count", 256'(count),     256'(0));
        chk("arst_stall", 256'(if_stall),  256'(0));
        chk("arst_id",    256'(id_packet), 256'(0));
        q.delete();
        m_k = 0;
        #1 reset = 1'b1;
        tick();
        drive(mk(1'b1, 32'h300, 1'b1, 32'h304), 2'd0, 1'b0);
        tick();
        drive(idle, 2'd0, 1'b0);
        chk("post_rst_count", 256'(count), 256'(2));
        tick();

        // Randomized traffic: fill-biased first half, drain-biased second
        for (int t = 0; t < 400; t++) begin
            rb = mk(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)), $urandom());
            drive(rb,
                  (t < 200) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 24) == 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/decode_buffer_ctrl.md
# decode_buffer_ctrl

Instruction buffer and dispatch scheduler between fetch and `stage_decode`. Accepts up to `N` `IF_ID_PACKET`s per cycle from fetch, holds them in a circular queue, and each cycle presents the oldest entries to the decoder, as many as the out-of-order backend reports it can accept. Generates the fetch stall and flushes all contents on a branch squash.

## Interface
- `N`, default `` `N ``: superscalar width.
- `DEPTH`, default 8: queue entries; power of two, `DEPTH >= 2*N`.
- `CNT_W`, default `$clog2(DEPTH+1)`: occupancy width.
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-low reset.
- `if_id_packet` in `IF_ID_PACKET [N-1:0]`: fetch bundle; each lane qualified by its `.valid` field.
- `dispatch_avail` in `$clog2(N+1)`: instructions the backend accepts this cycle (0..N).
- `squash` in 1: mispredict flush.
- `if_stall` out 1: fetch must hold its bundle; the bundle is not enqueued.
- `id_packet` out `IF_ID_PACKET [N-1:0]`: bundle to `stage_decode`; lanes `0..k-1` valid, the rest all-zero.
- `count` out `CNT_W`: current occupancy.

## Operation
- Storage: `DEPTH` × `IF_ID_PACKET`, plus `head`, `tail` (`$clog2(DEPTH)` bits, wrap mod `DEPTH`) and `count`.
- Stall: `if_stall = (DEPTH - count) < N`. Computed from registered `count` only. Same-cycle dequeues are not credited (conservative).
- Enqueue, when `!if_stall && !squash`:
  - Valid input lanes are compacted in lane order. Invalid lanes are skipped, so a bundle with valid lanes {1,3} writes lane 1 at `tail` and lane 3 at `tail+1`.
  - `e = popcount(valid)`; `tail += e`.
- Dequeue:
  - `k = min(count, dispatch_avail, N)`.
  - `id_packet[i] = buf[head+i]` for `i<k`, with `.valid=1`; lanes `i>=k` are zeroed.
  - On the clock edge: `head += k`.
- Occupancy update: `count_next = count + e - k`. Enqueue and dequeue in the same cycle are always legal.
- Squash takes priority over everything:
  - `id_packet` is all-zero in the squash cycle and `k=0`.
  - Incoming bundle is dropped (`e=0`).
  - Next cycle: `head=tail=count=0`.
- Entries are never overwritten while live. Stall guarantees `count + e <= DEPTH`.
- `dispatch_avail > N` is treated as `N`.

## Timing
- Reset (asserted low, asynchronous): `head=tail=count=0`, `if_stall=0`, `id_packet` all-zero. Contents are don't-care.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency without bypass: an instruction enqueued at edge T appears on `id_packet` in cycle T+1 at the earliest.
- `id_packet`, `if_stall` and `count` are functions of registered state plus same-cycle `dispatch_avail` and `squash`. There is no combinational path from `if_id_packet` to outputs unless bypass is compiled in.
- Full: when `count > DEPTH-N`, `if_stall=1`. Dequeue still proceeds.
- Empty: `count=0` gives `k=0` and outputs all-zero.
- Wrap-around: reads and writes straddling index `DEPTH-1` → 0 are handled per lane, mod `DEPTH`.

## Configuration
- `DECODE_BYPASS_EN` defined:
  - Applies when `count==0`, `!squash` and `!if_stall`.
  - Compacted incoming lanes drive `id_packet` directly in the same cycle, `k = min(e, dispatch_avail, N)`.
  - Only the remaining `e-k` lanes are enqueued.
  - Minimum latency is 0 cycles. Adds an `if_id_packet`→`id_packet` combinational path.
- `DECODE_BYPASS_EN` undefined: no bypass; minimum latency 1 cycle as above.

## Test plan
- Reset: hold `reset=0` mid-run with `count=5`.
  - Outputs go to `count=0`, `if_stall=0`, `id_packet` zero immediately.
  - After release, one bundle with `e=2` gives `count=2` next cycle.
- Fill/stall (N=2, DEPTH=8, `dispatch_avail=0`): four 2-valid bundles give `count=8`, `if_stall=1`. A fifth bundle is not enqueued and `count` stays 8.
- Partial dispatch: `count=3` with `dispatch_avail=1`:
  - Lane 0 holds the oldest PC and lane 1 is zero.
  - Next cycle `count=2` and `id_packet[0].PC` is the second-oldest entry.
- Compaction plus wrap:
  - Setup: `head=tail=7`, input lane 0 invalid, lane 1 valid with PC `0x40`.
  - Result: entry 7 = PC `0x40`, `tail=0`.
  - A following 2-valid bundle with PCs `0x44`/`0x48` lands in entries 0/1.
  - With `dispatch_avail=2`, the decoder sees PCs `0x40`, `0x44` in order.
- Squash: `count=4`, `squash=1` with a valid input bundle and `dispatch_avail=2`. Outputs are zero that cycle and `count=0` next cycle; no input is enqueued.
- Bypass (`DECODE_BYPASS_EN`): empty queue, 2-valid bundle with PCs `0x80`/`0x84`, `dispatch_avail=1`.
  - PC `0x80` appears on `id_packet[0]` in the same cycle.
  - Next cycle `count=1` with PC `0x84` at `head`.
  - Without the macro, `id_packet` is zero in that cycle and `count=2` next cycle.
